// File: rtl/seq_multiplier_8x8_if.sv
// Handshake and operand/result bundle between a controller and the sequential multiplier.
interface seq_multiplier_8x8_if #(
    parameter int unsigned WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic               write_en;
    logic [2*WIDTH-1:0] product;

    // Controller side: issues requests, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, write_en, product
    );

    // Multiplier side: accepts requests, reports status and result.
    modport slave (
        input  start, a, b,
        output busy, done, write_en, product
    );
endinterface

// File: rtl/seq_multiplier_8x8.sv
// Shift-and-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH iterations,
// with a one-cycle done/write_en pulse feeding the downstream result register.
module seq_multiplier_8x8 #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    seq_multiplier_8x8_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] acc_sum;
    logic               last_iter;

    assign last_iter = (count_q == CW'(WIDTH - 1));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last iteration, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded directly from registered state.
    always_comb begin
        bus.busy     = (state_q == RUN);
        bus.done     = (state_q == DONE);
        bus.write_en = (state_q == DONE);
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Datapath next values: operand load in IDLE, one add-and-shift step per RUN cycle.
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // The result register takes this iteration's sum, not the stale accumulator.
                if (last_iter) begin
                    product_d = acc_sum;
                end
            end
            default: ;
        endcase
    end

    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_multiplier_8x8.sv
// Directed self-checking bench for the sequential 8x8 multiplier.
module tb_seq_multiplier_8x8;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    seq_multiplier_8x8_if #(.WIDTH(8)) bus ();

    seq_multiplier_8x8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and report what was observed; callers do the comparisons.
    task automatic do_op(input logic [7:0] a_in, input logic [7:0] b_in,
                         output int lat, output int busy_cnt, output logic [15:0] prod,
                         output logic we, output logic done_after);
        bus.a     = a_in;
        bus.b     = b_in;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            lat++;
            @(posedge clk); #1;
        end
        prod = bus.product;
        we   = bus.write_en;
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        vectors++; if (bus.write_en !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b exp=0", bus.write_en); end
        vectors++; if (bus.product !== 16'h0000) begin miscompares++; $display("FAIL reset_product got=%h exp=0000", bus.product); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bc; logic [15:0] p; logic we, da;
        do_op(8'h0C, 8'h0A, lat, bc, p, we, da);
        vectors++; if (lat != 8) begin miscompares++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        vectors++; if (bc != 8) begin miscompares++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        vectors++; if (p !== 16'h0078) begin miscompares++; $display("FAIL basic_product got=%h exp=0078", p); end
        vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL basic_write_en got=%b exp=1", we); end
        vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL basic_single_pulse got=%b exp=0", da); end
        vectors++; if (bus.product !== 16'h0078) begin miscompares++; $display("FAIL basic_product_hold got=%h exp=0078", bus.product); end
    endtask

    task automatic test_corners();
        logic [7:0]  ta [3] = '{8'hFF, 8'h00, 8'h01};
        logic [7:0]  tb [3] = '{8'hFF, 8'hB7, 8'h80};
        logic [15:0] te [3] = '{16'hFE01, 16'h0000, 16'h0080};
        int lat, bc; logic [15:0] p; logic we, da;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], lat, bc, p, we, da);
            vectors++; if (lat != 8) begin miscompares++; $display("FAIL corner%0d_latency got=%0d exp=8", i, lat); end
            vectors++; if (p !== te[i]) begin miscompares++; $display("FAIL corner%0d_product got=%h exp=%h", i, p, te[i]); end
            vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL corner%0d_single_pulse got=%b exp=0", i, da); end
        end
    endtask

    task automatic test_ignore_start();
        int lat; int pulses;
        bus.a = 8'h03; bus.b = 8'h05; bus.start = 1'b1;
        @(posedge clk); #1;            // E0
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (lat == 2) begin
                bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            lat++;
            @(posedge clk); #1;
        end
        vectors++; if (lat != 8) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
        vectors++; if (bus.product !== 16'h000F) begin miscompares++; $display("FAIL ignore_product got=%h exp=000F", bus.product); end
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL ignore_extra_done got=%0d exp=0", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses; int first_at; int second_at;
        pulses = 0; first_at = -1; second_at = -1;
        bus.a = 8'h10; bus.b = 8'h10; bus.start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                pulses++;
                if (pulses == 1) first_at = i;
                if (pulses == 2) second_at = i;
                vectors++; if (bus.product !== 16'h0100) begin miscompares++; $display("FAIL b2b_product got=%h exp=0100", bus.product); end
            end
        end
        bus.start = 1'b0;
        vectors++; if (pulses != 2) begin miscompares++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses); end
        vectors++; if (second_at - first_at != 10) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=10", second_at - first_at); end
        vectors++; if (first_at != 8) begin miscompares++; $display("FAIL b2b_first_done got=%0d exp=8", first_at); end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int lat, bc; logic [15:0] p; logic we, da; int pulses;
        do_op(8'h0C, 8'h0A, lat, bc, p, we, da);
        vectors++; if (p !== 16'h0078) begin miscompares++; $display("FAIL abort_pre_product got=%h exp=0078", p); end
        bus.a = 8'h02; bus.b = 8'h03; bus.start = 1'b1;
        @(posedge clk); #1;            // E0
        bus.start = 1'b0;
        repeat (3) @(posedge clk);     // E1..E3
        #1;
        reset = 1'b1;
        @(posedge clk); #1;            // E4 with reset
        reset = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.product !== 16'h0000) begin miscompares++; $display("FAIL abort_product got=%h exp=0000", bus.product); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL abort_done got=%0d exp=0", pulses); end
        do_op(8'h02, 8'h03, lat, bc, p, we, da);
        vectors++; if (p !== 16'h0006) begin miscompares++; $display("FAIL abort_fresh_product got=%h exp=0006", p); end
        vectors++; if (lat != 8) begin miscompares++; $display("FAIL abort_fresh_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_reset_start();
        int busy_seen;
        bus.a = 8'h05; bus.b = 8'h07;
        reset = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_busy got=%b exp=0", bus.busy); end
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1 || bus.done === 1'b1) busy_seen++;
        end
        vectors++; if (busy_seen != 0) begin miscompares++; $display("FAIL rst_start_activity got=%0d exp=0", busy_seen); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_reset_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_multiplier_8x8.md
# seq_multiplier_8x8

Sequential shift-and-add unsigned multiplier that computes an 8×8 → 16-bit product over eight iterations. It is the stage directly upstream of the 16-bit result register in the arithmetic datapath. It presents the finished product on `product` and pulses `write_en` for one cycle, so the downstream register captures each result exactly once. A start/busy/done handshake lets a controller issue one multiplication at a time.

## Interface
- `WIDTH`, default 8: operand width. The product is 2·WIDTH bits, and 16 is required for the downstream register.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start` input 1: request a multiplication. Sampled only in IDLE.
- `a` input WIDTH: multiplicand, unsigned. Sampled with `start`.
- `b` input WIDTH: multiplier, unsigned. Sampled with `start`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when a result is complete.
- `write_en` output 1: equal to `done`. Drives the write enable of the downstream register.
- `product` output 2·WIDTH: latest completed product. Holds its value between completions.

## Operation
- Internal registers:
  - `mcand`: 2·WIDTH bits, zero-extended `a`.
  - `mplier`: WIDTH bits.
  - `acc`: 2·WIDTH bits.
  - `count`: 0..WIDTH-1, ⌈log2 WIDTH⌉ bits.
  - `product_r`: 2·WIDTH bits.
  - `state`: one of IDLE, RUN, DONE.
- IDLE:
  - If `start`=1 at an edge: load `mcand` = {WIDTH'0, a}, `mplier` = b, `acc` = 0, `count` = 0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN: on each edge,
  - If `mplier[0]`, then `acc` ← `acc` + `mcand`, with the sum truncated to 2·WIDTH bits. No overflow is possible.
  - `mcand` ← `mcand` << 1, `mplier` ← `mplier` >> 1, `count` ← `count` + 1.
  - When `count` = WIDTH-1, this is the last iteration: `product_r` ← the final accumulated value (including this iteration's add), and go to DONE.
- DONE: `done` = `write_en` = 1 for this single cycle. Go to IDLE at the next edge unconditionally.
- `start` in RUN or DONE is ignored. No queuing. Operands `a` and `b` are don't-care outside the IDLE sampling edge.
- `busy` = (state == RUN). `done` = `write_en` = (state == DONE). All three are decoded from registered state, so they are glitch-free.
- `product` = `product_r`. It updates only on the final RUN edge, so it is stable and valid throughout the `done` cycle and afterwards.
- Reset (in any state, including mid-RUN or in DONE):
  - state = IDLE; `acc`, `mcand`, `mplier`, `count`, `product_r` = 0.
  - `busy` = `done` = `write_en` = 0, `product` = 0.
  - An aborted operation produces no `done` pulse.
- Reset has priority over `start` when both are high on the same edge.

## Timing
- Edge E0: `start` sampled in IDLE.
- Edges E1..E8 (WIDTH edges): iterations run. `busy` is high during cycles E0+..E8−, i.e. exactly WIDTH cycles.
- Edge E8: `product` updates and state becomes DONE. `done`/`write_en` are high between E8 and E9.
- Edge E9: the downstream register captures `product`, and state returns to IDLE.
- Latency from the `start` edge to the `done` assertion edge: WIDTH edges. Start-to-start throughput: WIDTH+2 cycles. The earliest accepted next `start` is at E10, if held high from E9 onward.
- `start` held high continuously gives back-to-back operations every WIDTH+2 cycles, each with one `done` pulse.

## Test plan
- After reset: `busy` = `done` = `write_en` = 0 and `product` = 0x0000. Apply a=0x0C, b=0x0A with `start` for 1 cycle → `busy` high for 8 cycles, then `done`/`write_en` high for exactly 1 cycle with `product` = 0x0078.
- a=0xFF, b=0xFF → `product` = 0xFE01. Also a=0x00, b=0xB7 → 0x0000, and a=0x01, b=0x80 → 0x0080. Each gives `done` exactly 8 edges after the `start` edge.
- Pulse `start` with a=0x03, b=0x05, then pulse `start` again with a=0xFF, b=0xFF at cycle 3 of RUN → result is 0x000F, and the second request is ignored (no extra `done`).
- Hold `start`=1 for 25 cycles with a=0x10, b=0x10 → exactly 2 `done` pulses, 10 cycles apart, each with `product` = 0x0100.
- Complete 0x0C×0x0A (`product` = 0x0078), start 0x02×0x03, then assert `reset` at cycle 4 of RUN → next cycle: IDLE, `product` = 0x0000, no `done`. A fresh 0x02×0x03 then yields 0x0006.
- `reset` and `start` high on the same edge → remains IDLE and `busy` stays 0.
